// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Buffered 8N1 UART transmitter. Bytes arrive through a
//            valid/ready handshake into a one-entry holding register and are
//            serialized LSB-first with start and stop bits. A byte queued
//            during a frame starts immediately after that frame's stop bit,
//            with no idle gap.
// Macro    : UART_TX_PARITY_EN - when defined, an even-parity bit is inserted
//            between data bit 7 and the stop bit (8E1 framing).
// Ports    : i_Clock     - system clock, rising edge
//            i_Rst_L     - synchronous active-low reset
//            i_TX_DV     - byte-valid strobe (accepted when o_TX_Ready = 1)
//            i_TX_Byte   - byte to send, sampled on the accepting edge
//            o_TX_Ready  - holding register empty
//            o_TX_Active - a frame is on the line
//            o_TX_Serial - serial line, idle high, registered
//            o_TX_Done   - one-cycle pulse on the last clock of a stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_hold;
  logic               r_full;
  logic               r_serial;
  logic               r_active;
  logic               r_done;
  logic               w_bit_end;
  logic               w_load;
  logic               w_accept;
  logic               w_serial_next;
  logic               w_done_next;

  assign w_bit_end   = (r_clk_cnt == c_CNT_LAST);
  assign w_accept    = i_TX_DV & ~r_full;
  assign w_done_next = (r_state == S_STOP) & w_bit_end;

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, holding-register drain and the line value for the current
  // state. The line is registered from this value, so it trails the state by
  // one clock; Done and Active are registered alongside it to stay aligned.
  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_serial_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_full) begin
          w_state_next = S_START;
          w_load       = 1'b1;
        end
      end
      S_START: begin
        w_serial_next = 1'b0;
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_serial_next = r_shift[r_bit_idx];
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_serial_next = ^r_shift;
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_serial_next = 1'b1;
        if (w_bit_end) begin
          // A queued byte goes straight into the next start bit.
          if (r_full) begin
            w_state_next = S_START;
            w_load       = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counters, holding register, shift register and registered outputs
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_hold    <= 8'd0;
      r_full    <= 1'b0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Both counters restart on every state change so each bit is exactly
      // CLKS_PER_BIT clocks regardless of how the state was entered.
      if ((w_state_next != r_state) || (r_state == S_IDLE) || w_bit_end) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + c_CNT_W'(1);
      end

      if (w_state_next != r_state) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      // Accept and drain are mutually exclusive: a drain needs r_full = 1,
      // an accept needs r_full = 0.
      if (w_load) begin
        r_shift <= r_hold;
        r_full  <= 1'b0;
      end else if (w_accept) begin
        r_hold  <= i_TX_Byte;
        r_full  <= 1'b1;
      end

      r_serial <= w_serial_next;
      r_active <= (r_state != S_IDLE);
      r_done   <= w_done_next;
    end
  end

  assign o_TX_Ready  = ~r_full;
  assign o_TX_Active = r_active;
  assign o_TX_Serial = r_serial;
  assign o_TX_Done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. A frame-level reference model
//            schedules each accepted byte on the line and predicts Serial,
//            Ready, Active and Done every cycle. Directed table vectors and
//            hand-written sequences cover latency, back-to-back frames,
//            overflow and reset mid-frame; a random phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int c_CLKS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int c_FB = 11;
`else
  localparam int c_FB = 10;
`endif
  localparam int c_TMO = 40 * c_CLKS;

  logic r_clk  = 1'b0;
  logic r_rst_l = 1'b0;
  logic r_dv   = 1'b0;
  logic [7:0] r_byte = 8'd0;
  logic w_ready, w_active, w_serial, w_done;

  always #5 r_clk = ~r_clk;

  uart_tx #(.CLKS_PER_BIT(c_CLKS)) u_dut (
    .i_Clock    (r_clk),
    .i_Rst_L    (r_rst_l),
    .i_TX_DV    (r_dv),
    .i_TX_Byte  (r_byte),
    .o_TX_Ready (w_ready),
    .o_TX_Active(w_active),
    .o_TX_Serial(w_serial),
    .o_TX_Done  (w_done)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // Each accepted byte gets a line start cycle: two cycles after acceptance,
  // or the first cycle after the previous frame ends, whichever is later.
  typedef struct {
    longint     start;
    logic [7:0] data;
  } frame_t;

  frame_t q[$];
  longint t_free = 0;

  // Ready is low from the accept cycle until the cycle before the start bit.
  function automatic logic model_ready(input longint c);
    if (q.size() > 0 && c <= q[q.size()-1].start - 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  always @(posedge r_clk) begin : p_model
    logic   rdy;
    longint s;
    rdy = model_ready(cyc);
    cyc = cyc + 1;
    if (!r_rst_l) begin
      q.delete();
      t_free = 0;
    end else if (r_dv && rdy) begin
      s = (cyc + 2 > t_free) ? cyc + 2 : t_free;
      q.push_back('{start: s, data: r_byte});
      t_free = s + c_FB * c_CLKS;
    end
  end

  always @(negedge r_clk) begin : p_checker
    logic   e_line, e_act, e_done;
    longint off;
    if (chk_en) begin
      while (q.size() > 0 && q[0].start + c_FB * c_CLKS <= cyc) void'(q.pop_front());
      e_line = 1'b1; e_act = 1'b0; e_done = 1'b0;
      if (q.size() > 0 && cyc >= q[0].start) begin
        off    = cyc - q[0].start;
        e_line = frame_bit(q[0].data, int'(off / c_CLKS));
        e_act  = 1'b1;
        e_done = (off == c_FB * c_CLKS - 1);
      end
      check("cycle_outputs{serial,ready,active,done}",
            {28'd0, w_serial, w_ready, w_active, w_done},
            {28'd0, e_line, model_ready(cyc), e_act, e_done});
    end
  end

  // ---------------- helper tasks ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;  // bit 0 = start bit, bits 8:1 = data, bit 9 = stop
    logic       exp_par;
  } vec_t;

  function automatic logic [10:0] expected_bits(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.exp_par, v.exp_frame[8:0]};
`else
    return {1'b0, v.exp_frame};
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    for (n = 0; n < c_TMO && w_ready !== 1'b1; n++) @(negedge r_clk);
    check("send_ready", {31'd0, w_ready}, 32'd1);
    r_dv = 1'b1; r_byte = b;
    @(negedge r_clk);
    r_dv = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < c_TMO && !(w_active === 1'b0 && w_ready === 1'b1); n++) @(negedge r_clk);
    check("wait_idle{active,ready}", {30'd0, w_active, w_ready}, 32'd1);
  endtask

  // Samples one frame at bit centres; returns at the stop-bit centre.
  task automatic rx_frame(output logic [10:0] bits);
    int n;
    bits = '0;
    for (n = 0; n < c_TMO && w_serial !== 1'b0; n++) @(negedge r_clk);
    check("rx_start_found", {31'd0, w_serial}, 32'd0);
    repeat (c_CLKS / 2) @(negedge r_clk);
    for (int b = 0; b < c_FB; b++) begin
      bits[b] = w_serial;
      if (b != c_FB - 1) repeat (c_CLKS) @(negedge r_clk);
    end
  endtask

  initial begin : p_watchdog
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin : p_main
    vec_t        vecs[6];
    vec_t        v19;
    logic [10:0] bits, f1, f2;
    int          lows;

    vecs[0] = '{8'h37, 10'b1_00110111_0, 1'b1};
    vecs[1] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[4] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[5] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    v19     = '{8'h19, 10'b1_00011001_0, 1'b1};

    // Reset held for 5 cycles
    repeat (5) @(negedge r_clk);
    check("reset_state{serial,ready,active,done}",
          {28'd0, w_serial, w_ready, w_active, w_done}, 32'hC);
    chk_en  = 1'b1;
    r_rst_l = 1'b1;

    // Table-driven single frames from idle, with accept-to-line latency
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      send_byte(vecs[i].data);
      @(negedge r_clk);
      check("latency_edge_n1_high", {31'd0, w_serial}, 32'd1);
      @(negedge r_clk);
      check("latency_edge_n2_low", {31'd0, w_serial}, 32'd0);
      rx_frame(bits);
      check("frame_bits", {21'd0, bits}, {21'd0, expected_bits(vecs[i])});
    end

    // Back-to-back with an overflow attempt while the holding register is full
    wait_idle();
    fork
      begin
        rx_frame(f1);
        rx_frame(f2);
      end
      begin : b2b_drive
        int n;
        send_byte(8'h37);
        repeat (3 * c_CLKS) @(negedge r_clk);
        send_byte(8'h19);
        repeat (5) @(negedge r_clk);
        r_dv = 1'b1; r_byte = 8'hAA;
        @(negedge r_clk);
        r_dv = 1'b0;
        check("overflow_ready_low", {31'd0, w_ready}, 32'd0);
        for (n = 0; n < c_TMO && w_done !== 1'b1; n++) @(negedge r_clk);
        check("b2b_done_seen", {31'd0, w_done}, 32'd1);
        @(negedge r_clk);
        check("b2b_no_gap_start", {31'd0, w_serial}, 32'd0);
      end
    join
    check("b2b_frame1", {21'd0, f1}, {21'd0, expected_bits(vecs[0])});
    check("b2b_frame2", {21'd0, f2}, {21'd0, expected_bits(v19)});

    // Reset during data bit 3 of 0x55 with 0x0F queued behind it
    wait_idle();
    send_byte(8'h55);
    for (int n = 0; n < c_TMO && w_serial !== 1'b0; n++) @(negedge r_clk);
    send_byte(8'h0F);
    repeat (4 * c_CLKS - 1 + c_CLKS / 2) @(negedge r_clk);
    r_rst_l = 1'b0;
    @(negedge r_clk);
    check("rst_mid{serial,ready,active}",
          {29'd0, w_serial, w_ready, w_active}, 32'h6);
    r_rst_l = 1'b1;
    lows = 0;
    repeat (12 * c_CLKS) begin
      @(negedge r_clk);
      if (w_serial !== 1'b1) lows++;
    end
    check("rst_queued_byte_lost", lows, 32'd0);

    // Random strobes (often while not ready), random gaps and occasional resets
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 12 * c_CLKS));
      repeat (gap) @(negedge r_clk);
      if ($urandom_range(0, 19) == 0) begin
        r_rst_l = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge r_clk);
        r_rst_l = 1'b1;
      end else begin
        r_dv = 1'b1; r_byte = 8'($urandom);
        @(negedge r_clk);
        r_dv = 1'b0;
      end
    end
    wait_idle();
    repeat (5) @(negedge r_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, the transmit half of the board's 8N1 serial link, paired with the existing `UART_RX` receiver at the same baud settings. It accepts bytes through a valid/ready handshake into a one-entry holding register. It serializes each byte LSB-first with start and stop bits, and starts the next queued byte with no idle gap. The host-side command path uses it to send responses back over the serial port.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per serial bit (50 MHz / 115200); legal range 2..65535.
- `i_Clock`  in  1  system clock; all logic is on the rising edge.
- `i_Rst_L`  in  1  synchronous, active-low reset, sampled on `i_Clock`.
- `i_TX_DV`  in  1  byte-valid strobe; a byte is accepted when `i_TX_DV & o_TX_Ready`.
- `i_TX_Byte`  in  8  byte to send; sampled only on the accepting edge.
- `o_TX_Ready`  out  1  high when the holding register is empty.
- `o_TX_Active`  out  1  high while a frame is on the line.
- `o_TX_Serial`  out  1  serial line; idle high; registered output.
- `o_TX_Done`  out  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- **State machine:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **Counters:**
  - Clock counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1.
  - Bit index: 3 bits, counts 0..7.
  - Each counter resets to 0 on every state change.
- **Holding register:**
  - Written on an accepting edge, then flagged full.
  - `o_TX_Ready` = !full.
  - The flag clears on the edge where the byte moves into the shift register.
- **IDLE:** if the holding register is full, move it to the shift register and enter START.
- **START:** line = 0 for CLKS_PER_BIT cycles, then DATA.
- **DATA:**
  - Line = shift[bit index], sent LSB first, each bit CLKS_PER_BIT cycles.
  - After bit 7 completes, go to PARITY if enabled, otherwise STOP.
- **STOP:**
  - Line = 1 for CLKS_PER_BIT cycles.
  - `o_TX_Done` pulses on the final cycle.
  - On that same edge: if the holding register is full, load it and go to START directly (back-to-back); otherwise go to IDLE.
- **Accepting during a frame:** a byte may be accepted in any state while `o_TX_Ready`=1, so one byte can queue behind the frame in progress.
- **`o_TX_Active`:** 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **`i_TX_DV` while `o_TX_Ready`=0:** ignored; the byte is dropped and state is unchanged.
- **Accept and drain on the same edge:** cannot collide, because Ready is 0 on the drain edge.
- **Reset values:**
  - `o_TX_Serial`=1, `o_TX_Ready`=1, `o_TX_Active`=0, `o_TX_Done`=0.
  - State IDLE; counters 0; holding register empty.
- **Reset mid-frame:** the line returns high on the reset edge, the frame is truncated, and any queued byte is discarded.

## Timing
- **Latency from idle:** byte accepted on edge N; `o_TX_Serial` falls after edge N+2 (one cycle for the register write, one for the IDLE→START decision).
- **Frame length:** exactly 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- **Back-to-back frames:** no idle cycles between them. The next start bit begins on the cycle after the `o_TX_Done` cycle.
- **Ready recovery:** `o_TX_Ready` returns to 1 one cycle after the holding register drains, which is the first cycle of START.
- **Bit boundaries:** jitter-free; every bit is exactly CLKS_PER_BIT clocks.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:**
  - The PARITY state is compiled in.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between bit 7 and the stop bit.
  - Frame format becomes 8E1.
- **Undefined:** no parity state or logic; frame format is 8N1. The receiver must be built to match.

## Test plan
- **Reset:** hold `i_Rst_L`=0 for 5 cycles → Serial=1, Ready=1, Active=0, Done=0.
- **Single byte:** CLKS_PER_BIT=434, 20 ns clock, send 0x37 → line samples at bit centres (8680 ns period) read 0, 1,1,1,0,1,1,0,0, 1. Exactly one Done pulse; Active is high for 4340 cycles.
- **Back-to-back:**
  - Send 0x37, then 0x19 while Ready=1 mid-frame → second start bit begins on the cycle after the first Done, with zero idle cycles.
  - Loopback into `UART_RX` yields 0x37 then 0x19.
- **Overflow:** with the holding register full, assert DV with 0xAA → 0xAA is never transmitted and Ready stays 0 until the drain.
- **Reset mid-frame:** assert reset during bit 3 of 0x55 → the line is 1 the next cycle, the queued byte is lost, and Ready=1 afterwards.
- **Parity (`UART_TX_PARITY_EN`):** send 0x37 (five ones) → parity bit = 1 and the frame is 11 bits; send 0x03 → parity bit = 0.
